// File: rtl/hilo_seq.sv
// hilo_seq: multi-cycle HI/LO sequencer for the EX stage.
// Handles multiply-accumulate (MADD/MADDU/MSUB/MSUBU) in two cycles and
// 32-step restoring division (DIV/DIVU), returning {HI,LO} with a one-cycle
// ready strobe and a stall request toward the pipeline controller.
module hilo_seq #(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic [63:0] hilo_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o,
    output logic        stallreq_o
);

    localparam int CW = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(DIV_STEPS - 1);

    localparam logic [2:0] OP_MADD  = 3'b000;
    localparam logic [2:0] OP_MADDU = 3'b001;
    localparam logic [2:0] OP_MSUB  = 3'b010;
    localparam logic [2:0] OP_MSUBU = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MACC,
        S_DIV,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [63:0]    r_temp;
    logic [31:0]    r_divisor;
    logic           r_neg_quot;
    logic           r_neg_rem;
    logic [63:0]    r_result;
    logic           r_ready;

    logic           w_legal;
    logic           w_is_div;
    logic           w_unsigned;
    logic           w_negate;
    logic [63:0]    w_op1_ext;
    logic [63:0]    w_op2_ext;
    logic [63:0]    w_product;
    logic [63:0]    w_macc_init;
    logic           w_op1_neg;
    logic           w_op2_neg;
    logic [31:0]    w_dividend_mag;
    logic [31:0]    w_divisor_mag;
    logic [64:0]    w_div_shift;
    logic [33:0]    w_div_diff;
    logic [63:0]    w_div_next;
    logic [31:0]    w_quot_fixed;
    logic [31:0]    w_rem_fixed;

    // Decode the requested operation.
    always_comb begin
        w_legal    = 1'b0;
        w_is_div   = 1'b0;
        w_unsigned = op_i[0];
        w_negate   = 1'b0;
        case (op_i)
            OP_MADD, OP_MADDU: w_legal = 1'b1;
            OP_MSUB, OP_MSUBU: begin
                w_legal  = 1'b1;
                w_negate = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                w_legal  = 1'b1;
                w_is_div = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Product for the MACC path. Extending both operands to 64 bits (sign or
    // zero per op) lets a single unsigned 64x64 multiply serve both signednesses,
    // since only the low 64 bits are kept.
    always_comb begin
        w_op1_ext   = w_unsigned ? {32'd0, opdata1_i} : {{32{opdata1_i[31]}}, opdata1_i};
        w_op2_ext   = w_unsigned ? {32'd0, opdata2_i} : {{32{opdata2_i[31]}}, opdata2_i};
        w_product   = w_op1_ext * w_op2_ext;
        w_macc_init = w_negate ? (64'd0 - w_product) : w_product;
    end

    // Operand magnitudes for the division path; DIVU passes raw values.
    always_comb begin
        w_op1_neg      = ~w_unsigned & opdata1_i[31];
        w_op2_neg      = ~w_unsigned & opdata2_i[31];
        w_dividend_mag = w_op1_neg ? (32'd0 - opdata1_i) : opdata1_i;
        w_divisor_mag  = w_op2_neg ? (32'd0 - opdata2_i) : opdata2_i;
    end

    // One restoring-division step on {rem, quot}; the shifted remainder can
    // reach 33 bits, so the trial subtract is done at 34 bits to keep the sign.
    always_comb begin
        w_div_shift = {r_temp, 1'b0};
        w_div_diff  = {1'b0, w_div_shift[64:32]} - {2'b00, r_divisor};
        if (w_div_diff[33]) begin
            w_div_next = w_div_shift[63:0];
        end else begin
            w_div_next = {w_div_diff[31:0], w_div_shift[31:1], 1'b1};
        end
        w_quot_fixed = r_neg_quot ? (32'd0 - w_div_next[31:0])  : w_div_next[31:0];
        w_rem_fixed  = r_neg_rem  ? (32'd0 - w_div_next[63:32]) : w_div_next[63:32];
    end

    // Sequencer state, iteration counter, intermediate value and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_temp     <= '0;
            r_divisor  <= '0;
            r_neg_quot <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else if (annul_i) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (start_i && w_legal) begin
                        if (!w_is_div) begin
                            r_temp  <= w_macc_init;
                            r_state <= S_MACC;
                        end else if (opdata2_i == 32'd0) begin
                            r_result <= '0;
                            r_ready  <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_temp     <= {32'd0, w_dividend_mag};
                            r_divisor  <= w_divisor_mag;
                            r_neg_quot <= w_op1_neg ^ w_op2_neg;
                            r_neg_rem  <= w_op1_neg;
                            r_cnt      <= '0;
                            r_state    <= S_DIV;
                        end
                    end
                end
                S_MACC: begin
                    r_result <= r_temp + hilo_i;
                    r_ready  <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DIV: begin
                    r_temp <= w_div_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_result <= {w_rem_fixed, w_quot_fixed};
                        r_ready  <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall while a legal request is being accepted or work is in flight.
    always_comb begin
        stallreq_o = 1'b0;
        case (r_state)
            S_IDLE:        stallreq_o = start_i & w_legal & ~annul_i;
            S_MACC, S_DIV: stallreq_o = 1'b1;
            default:       stallreq_o = 1'b0;
        endcase
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = (r_state != S_IDLE);

endmodule

// File: tb/tb_hilo_seq.sv
// Self-checking bench for hilo_seq: directed operations against an
// arithmetic reference model, with per-cycle output comparison.
module tb_hilo_seq;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] hilo_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic        stallreq_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic        chk_en = 1'b0;
    logic        exp_ready;
    logic        exp_busy;
    logic        exp_stall;
    logic [63:0] exp_result;

    hilo_seq #(.DIV_STEPS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .hilo_i    (hilo_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o),
        .stallreq_o(stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {HI,LO} result from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] h);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [31:0]     uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'b000: return h + 64'(sa * sb);
            3'b001: return h + (ua * ub);
            3'b010: return h - 64'(sa * sb);
            3'b011: return h - (ua * ub);
            3'b100: begin
                if (b == 0) return 64'd0;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'b101: begin
                if (b == 0) return 64'd0;
                uq = a / b;
                ur = a % b;
                return {ur, uq};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Per-cycle comparison of every output against the model's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready_o", {63'd0, ready_o}, {63'd0, exp_ready});
            check("busy_o", {63'd0, busy_o}, {63'd0, exp_busy});
            check("stallreq_o", {63'd0, stallreq_o}, {63'd0, exp_stall});
            check("result_o", result_o, exp_result);
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Issue one operation starting this cycle and hold start until DONE.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] h,
                          input logic [63:0] lit);
        int          lat;
        logic        legal;
        logic [63:0] val;
        legal = (op <= 3'd5);
        val   = model(op, a, b, h);
        if (op[2] == 1'b0) lat = 2;
        else if (b == 0)   lat = 1;
        else               lat = 33;
        op_i      = op;
        opdata1_i = a;
        opdata2_i = b;
        hilo_i    = h;
        start_i   = 1'b1;
        if (!legal) begin
            for (int k = 0; k < 2; k++) begin
                exp_stall = 1'b0;
                exp_busy  = 1'b0;
                exp_ready = 1'b0;
                next_cycle();
            end
        end else begin
            for (int k = 0; k <= lat; k++) begin
                exp_stall = (k < lat);
                exp_busy  = (k > 0);
                exp_ready = (k == lat);
                if (k == lat) begin
                    exp_result = val;
                    @(negedge clk);
                    check(name, result_o, lit);
                    @(posedge clk);
                    #1;
                end else begin
                    next_cycle();
                end
            end
        end
        start_i   = 1'b0;
        exp_stall = 1'b0;
        exp_busy  = 1'b0;
        exp_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start_i    = 1'b0;
        op_i       = 3'b000;
        opdata1_i  = '0;
        opdata2_i  = '0;
        hilo_i     = '0;
        annul_i    = 1'b0;
        exp_ready  = 1'b0;
        exp_busy   = 1'b0;
        exp_stall  = 1'b0;
        exp_result = '0;

        @(posedge clk); #1;
        @(posedge clk); #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        next_cycle();

        // Pin the reference model with hand-computed values.
        check("model_madd", model(3'b000, 32'hFFFFFFFE, 32'd3, 64'h10), 64'hA);
        check("model_msubu", model(3'b011, 32'hFFFFFFFF, 32'd2, 64'h0), 64'hFFFFFFFE_00000002);
        check("model_div", model(3'b100, 32'hFFFFFFF9, 32'd2, 64'h0), {32'hFFFFFFFF, 32'hFFFFFFFD});
        check("model_divu", model(3'b101, 32'hFFFFFFFF, 32'd16, 64'h0), {32'hF, 32'h0FFFFFFF});

        run_op("madd",  3'b000, 32'hFFFFFFFE, 32'd3, 64'h10, 64'hA);
        run_op("msubu", 3'b011, 32'hFFFFFFFF, 32'd2, 64'h0, 64'hFFFFFFFE_00000002);
        run_op("msub",  3'b010, 32'd7, 32'hFFFFFFFD, 64'd100, 64'h79);
        run_op("maddu", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1, 64'hFFFFFFFE_00000002);
        run_op("div_neg", 3'b100, 32'hFFFFFFF9, 32'd2, 64'h0, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op("divu_big", 3'b101, 32'hFFFFFFFF, 32'd16, 64'h0, {32'hF, 32'h0FFFFFFF});
        run_op("div_negdivisor", 3'b100, 32'd7, 32'hFFFFFFFE, 64'h0, {32'h1, 32'hFFFFFFFD});
        run_op("div_minint", 3'b100, 32'h80000000, 32'hFFFFFFFF, 64'h0, {32'h0, 32'h80000000});
        run_op("divu_small", 3'b101, 32'd100, 32'd7, 64'h0, {32'd2, 32'd14});
        run_op("div_zero", 3'b100, 32'd1234, 32'd0, 64'h0, 64'h0);
        run_op("illegal", 3'b111, 32'd5, 32'd6, 64'h0, 64'h0);
        run_op("madd_b2b", 3'b000, 32'd4, 32'd5, 64'h0, 64'd20);

        // Flush a division at cycle 10, then start a MADD in the cycle after.
        op_i      = 3'b100;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_stall = 1'b1;
            exp_busy  = (k > 0);
            exp_ready = 1'b0;
            next_cycle();
        end
        annul_i   = 1'b1;
        start_i   = 1'b0;
        exp_stall = 1'b1;
        exp_busy  = 1'b1;
        exp_ready = 1'b0;
        next_cycle();
        annul_i   = 1'b0;
        exp_stall = 1'b0;
        exp_busy  = 1'b0;
        check("annul_stall", {63'd0, stallreq_o}, 64'd0);
        check("annul_busy", {63'd0, busy_o}, 64'd0);
        check("annul_ready", {63'd0, ready_o}, 64'd0);
        run_op("madd_after_annul", 3'b000, 32'd2, 32'd3, 64'd1, 64'd7);

        // Reset while in MACC clears every output.
        op_i      = 3'b000;
        opdata1_i = 32'd5;
        opdata2_i = 32'd6;
        hilo_i    = 64'd1;
        start_i   = 1'b1;
        exp_stall = 1'b1;
        exp_busy  = 1'b0;
        next_cycle();
        rst       = 1'b1;
        start_i   = 1'b0;
        exp_stall = 1'b1;
        exp_busy  = 1'b1;
        next_cycle();
        rst        = 1'b0;
        exp_stall  = 1'b0;
        exp_busy   = 1'b0;
        exp_ready  = 1'b0;
        exp_result = 64'd0;
        @(negedge clk);
        check("rst_result", result_o, 64'd0);
        @(posedge clk); #1;
        next_cycle();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_seq.md
Name: hilo_seq

Overview:
- Multi-cycle sequencer for the HI/LO-writing operations of the EX stage: MADD/MADDU/MSUB/MSUBU (multiply then accumulate) and DIV/DIVU (32-step restoring division).
- Owns the operation state, the iteration counter and the 64-bit intermediate value, and drives the EX stall request.
- Returns a 64-bit {HI,LO} result with a one-cycle ready strobe.
- EX keeps start_i and the operands stable while stalled, and writes result_o to HI/LO when ready_o is high.

Parameters:
- DIV_STEPS, 32, number of division iterations; equals the operand width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start_i  input  1  operation request from EX; held while stallreq_o=1.
- op_i  input  3  000 MADD, 001 MADDU, 010 MSUB, 011 MSUBU, 100 DIV, 101 DIVU; 110/111 illegal.
- opdata1_i  input  32  multiplicand or dividend.
- opdata2_i  input  32  multiplier or divisor.
- hilo_i  input  64  forwarded {HI,LO}; sampled in the MACC cycle.
- annul_i  input  1  flush; abort the current operation.
- result_o  output  64  {HI,LO} result; for division {remainder, quotient}.
- ready_o  output  1  result valid, one-cycle strobe.
- busy_o  output  1  state is not IDLE.
- stallreq_o  output  1  stall request to the pipeline controller.

Behaviour:
- States are IDLE, MACC, DIV, DONE. rst has priority over everything and sets state=IDLE, cnt=0, result_o=0, ready_o=0, temp=0.
- annul_i=1, in any state: next state is IDLE and ready_o=0 next cycle; result_o holds its value. annul_i has priority over start_i.
- IDLE:
  - start_i with op 000-011: register the 64-bit product in temp, go to MACC.
  - Signed ops (MADD, MSUB) use a two's-complement 32x32 multiply; unsigned ops (MADDU, MSUBU) zero-extend.
  - MSUB/MSUBU store the negated product.
- IDLE, start_i with op 100/101:
  - Divisor == 0: result_o=64'h0, go to DONE.
  - Otherwise load |dividend| and |divisor| (DIV) or the raw values (DIVU), set cnt=0, go to DIV.
- IDLE, illegal op: no action, no stall.
- MACC: result_o <= temp + hilo_i (mod 2^64), go to DONE.
- DIV:
  - Each cycle performs one restoring step: shift {rem,quot} left by 1, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - cnt increments each cycle. After the step with cnt == DIV_STEPS-1, go to DONE.
  - Final sign fix for DIV: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - The sign fix is applied when writing result_o.
- DONE:
  - ready_o=1 for exactly one cycle, then unconditionally IDLE.
  - start_i seen in DONE is the same instruction and is ignored.
  - A new start_i is accepted in the following IDLE cycle, so back-to-back operations have no dead cycle beyond DONE.
- stallreq_o is combinational and is 1 when either:
  - state==IDLE && start_i && legal op && !annul_i, or
  - state is MACC or DIV.
- stallreq_o is 0 in DONE and after reset.
- Latency, with start seen at cycle 0:
  - MADD/MSUB: ready at cycle 2, 2 stall cycles.
  - DIV: ready at cycle 33.
  - Divide-by-zero: ready at cycle 1.
- result_o is stable from DONE until the next update. ready_o is registered.

Test Plan:
- MADD, hilo_i=64'h10, op1=32'hFFFFFFFE (-2), op2=3 -> stallreq_o=1 for cycles 0-1; ready_o=1 at cycle 2; result_o=64'hA.
- MSUBU, hilo_i=0, op1=32'hFFFFFFFF, op2=2 -> result_o=64'hFFFFFFFE_00000002 at cycle 2.
- DIV -7/2 (32'hFFFFFFF9, 2) -> ready_o at cycle 33; result_o={32'hFFFFFFFF, 32'hFFFFFFFD}. DIVU 32'hFFFFFFFF/16 -> {32'hF, 32'h0FFFFFFF}.
- DIV by 0 -> ready_o at cycle 1, result_o=0, stallreq_o=1 only in cycle 0.
- annul_i at cycle 10 of DIV -> IDLE at cycle 11, no ready_o, stallreq_o=0. A new MADD started at cycle 11 completes at cycle 13 with the correct value.
- rst asserted in the MACC state -> all outputs 0 next cycle. Illegal op 3'b111 with start_i -> stallreq_o=0, busy_o stays 0.
